ts_channel_monitor: RTL and testbench
=====================================

# ts_channel_monitor

Per-channel MPEG-2 TS input monitor: acquires 188-byte packet sync on a byte stream, parses the 4-byte header, and checks transport errors and continuity-counter (CC) discontinuities on one selected PID. It produces the per-channel `signal_present` bit and the 8-bit saturating error count. These feed the QoS channel-selection controller: four instances drive `valid[3:0]` and `err_count[31:0]` (instance n on bits [8n+7:8n]). The controller's `en_reset_counter` drives `clr_count` on every instance.

## Interface
- `PKT_LEN`, 188: bytes per TS packet.
- `LOCK_COUNT`, 3: consecutive correctly spaced sync bytes required to lock (≥2).
- `LOSS_COUNT`, 3: consecutive missing sync bytes, while locked, that drop lock (≥1).
- `TIMEOUT`, 65535: idle cycles without `ts_valid` that force loss of signal (16-bit counter).
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ts_data` in 8: TS byte; accepted only when `ts_valid`=1.
- `ts_valid` in 1: byte strobe; arbitrary gaps allowed.
- `pid_sel` in 13: PID whose CC is checked.
- `clr_count` in 1: synchronous clear of `err_count`.
- `signal_present` out 1: channel locked and not timed out.
- `err_count` out 8: saturating error total.
- `cc_err` out 1: one-cycle pulse per counted error of any kind.
- `pkt_start` out 1: one-cycle pulse when an accepted sync byte (0x47) starts a packet in LOCKED.

## Operation
- `byte_idx` (0..PKT_LEN-1) advances only on accepted bytes and wraps PKT_LEN-1→0. Index 0 is the expected sync position.
- FSM states: HUNT, PRESYNC, LOCKED.
- HUNT: an accepted 0x47 → PRESYNC, `byte_idx`=1, `good`=1. Any other byte: stay in HUNT.
- PRESYNC: on the byte at index 0:
  - 0x47: `good`+1; when `good` reaches LOCK_COUNT → LOCKED, `bad`=0.
  - anything else: → HUNT (that byte is not re-examined as a sync candidate).
- LOCKED: on the byte at index 0:
  - 0x47: `bad`=0, `pkt_start` pulses.
  - anything else: `bad`+1; when `bad` reaches LOSS_COUNT → HUNT and one error is counted.
  - Header parsing for a packet whose sync byte was missing is suppressed.
- Header fields (LOCKED only, after a valid sync):
  - byte 1: TEI=bit7, PID[12:8]=bits[4:0]
  - byte 2: PID[7:0]
  - byte 3: AFC=bits[5:4], CC=bits[3:0]
- TEI=1: one error is counted at byte 1. The packet is then excluded from the CC check.
- CC check at byte 3 runs only when PID==`pid_sel`, PID≠0x1FFF and TEI=0:
  - If `cc_ok`=0: load `last_cc`, set `cc_ok`, no check.
  - AFC∈{01,11} (payload present): expected = `last_cc`+1 mod 16.
    - CC==`last_cc`, first time: duplicate, not an error, sets `dup`.
    - CC==`last_cc`, second consecutive time: error.
    - Any other mismatch: error.
  - AFC∈{00,10}: expected = `last_cc`; a mismatch is an error.
  - After every check, `last_cc`=CC; `dup` is cleared on any non-duplicate.
- `cc_ok` and `dup` clear on entry to HUNT and whenever `pid_sel` differs from its registered copy (compared every cycle).
- Idle counter: cleared on `ts_valid`, else increments and saturates at TIMEOUT.
  - Reaching TIMEOUT forces HUNT from any state.
  - Counts one error only if the state was LOCKED.
- `signal_present` = (state==LOCKED), registered.
- `err_count` rules:
  - An error event increments it, saturating at 255.
  - `clr_count` sets it to 0; `clr_count` together with an event sets it to 1.
  - Error sources occur at different byte indices, so at most one event occurs per cycle. The timeout transition and a missing-sync transition are mutually exclusive, since a byte was accepted on that cycle.

## Timing
- Reset values: `signal_present`=0, `err_count`=0, `cc_err`=0, `pkt_start`=0. FSM=HUNT, `cc_ok`=0, `dup`=0, `byte_idx`=0, idle=0.
- All outputs are registered with 1-cycle latency from the accepting edge of the triggering byte:
  - `signal_present` rises the cycle after the LOCK_COUNT-th sync is accepted.
  - `signal_present` falls the cycle after lock loss or timeout.
- `cc_err` pulses in the same cycle `err_count` updates, including when `err_count` is saturated.
- `rst` mid-packet: everything returns to reset values immediately; reacquisition restarts from HUNT.
- `clr_count` does not affect sync or CC state.

## Test plan
- Reset, then 3 clean packets (PID 0x100, CC 0,1,2, AFC=01), `pid_sel`=0x100 → `signal_present`=1 one cycle after the 3rd sync byte; `err_count`=0.
- Locked stream with CC sequence 3,4,6 on `pid_sel` → one `cc_err` pulse at byte 3 of the CC=6 packet; `err_count`=1. Sequence 5,5 → no error; sequence 5,5,5 → `err_count`+1.
- One packet with TEI=1 and CC out of order → exactly 1 error (TEI only). Packet on PID 0x1FFF with a random CC → no error.
- Corrupt 3 consecutive sync bytes while locked → `signal_present` falls after the 3rd bad byte and `err_count`+1. Corrupt 2 then one good sync → lock held, `bad` reset.
- Stop `ts_valid` for TIMEOUT cycles while locked → `signal_present`=0 and `err_count`+1. Resume with clean packets → relock after 3 syncs; first CC after relock is not checked.
- Drive 300 CC errors → `err_count` holds at 255 with `cc_err` still pulsing. Assert `clr_count` on the same cycle as an error → `err_count`=1.

Source files
------------

// File: rtl/ts_channel_monitor_if.sv
// rtl/ts_channel_monitor_if.sv - TS byte stream bundle between source and channel monitor
interface ts_channel_monitor_if;
   logic [7:0] ts_data;
   logic       ts_valid;

   modport master (output ts_data, output ts_valid);
   modport slave  (input ts_data, input ts_valid);
endinterface

// File: rtl/ts_channel_monitor.sv
// rtl/ts_channel_monitor.sv - MPEG-2 TS sync acquisition, header parse and CC/TEI error counting
module ts_channel_monitor #(
   parameter int PKT_LEN    = 188,
   parameter int LOCK_COUNT = 3,
   parameter int LOSS_COUNT = 3,
   parameter int TIMEOUT    = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   ts_channel_monitor_if.slave   ts,
   input  logic [12:0]           pid_sel,
   input  logic                  clr_count,
   output logic                  signal_present,
   output logic [7:0]            err_count,
   output logic                  cc_err,
   output logic                  pkt_start
);
   localparam int IDX_W = $clog2(PKT_LEN);

   typedef enum logic [1:0] {HUNT, PRESYNC, LOCKED} state_t;

   state_t           state;
   logic [IDX_W-1:0] byte_idx;
   logic [7:0]       good;
   logic [7:0]       bad;
   logic [15:0]      idle;
   logic             hdr_ok;
   logic             tei;
   logic             cc_ok;
   logic             dup;
   logic [4:0]       pid_hi;
   logic [7:0]       pid_lo;
   logic [3:0]       last_cc;
   logic [12:0]      pid_sel_q;

   logic        is_sync;
   logic        at_zero;
   logic        last_idx;
   logic        timeout_hit;
   logic        loss_hit;
   logic        tei_hit;
   logic        cc_match;
   logic        cc_hit;
   logic        err_event;
   logic [3:0]  cc;
   logic [12:0] cur_pid;

   assign is_sync  = (ts.ts_data == 8'h47);
   assign at_zero  = (byte_idx == '0);
   assign last_idx = (byte_idx == IDX_W'(PKT_LEN - 1));
   assign cc       = ts.ts_data[3:0];
   assign cur_pid  = {pid_hi, pid_lo};

   // Timeout fires on the idle cycle that brings the counter to TIMEOUT, so it never
   // coincides with an accepted byte.
   assign timeout_hit = !ts.ts_valid && (idle == 16'(TIMEOUT - 1));
   assign loss_hit    = ts.ts_valid && (state == LOCKED) && at_zero && !is_sync
                        && (bad == 8'(LOSS_COUNT - 1));
   assign tei_hit     = ts.ts_valid && (state == LOCKED) && hdr_ok
                        && (byte_idx == IDX_W'(1)) && ts.ts_data[7];
   assign cc_match    = ts.ts_valid && (state == LOCKED) && hdr_ok
                        && (byte_idx == IDX_W'(3)) && (cur_pid == pid_sel)
                        && (cur_pid != 13'h1FFF) && !tei;

   always_comb begin
      cc_hit = 1'b0;
      if (cc_match && cc_ok) begin
         if (ts.ts_data[4]) begin
            // A single repeated CC is a legal duplicate; a second repeat is not.
            cc_hit = (cc == last_cc) ? dup : (cc != last_cc + 4'd1);
         end else begin
            cc_hit = (cc != last_cc);
         end
      end
   end

   assign err_event = (timeout_hit && (state == LOCKED)) || loss_hit || tei_hit || cc_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= HUNT;
         byte_idx       <= '0;
         good           <= 8'd0;
         bad            <= 8'd0;
         idle           <= 16'd0;
         hdr_ok         <= 1'b0;
         tei            <= 1'b0;
         cc_ok          <= 1'b0;
         dup            <= 1'b0;
         pid_hi         <= 5'd0;
         pid_lo         <= 8'd0;
         last_cc        <= 4'd0;
         pid_sel_q      <= 13'd0;
         signal_present <= 1'b0;
         err_count      <= 8'd0;
         cc_err         <= 1'b0;
         pkt_start      <= 1'b0;
      end else begin
         pkt_start <= 1'b0;
         cc_err    <= err_event;
         pid_sel_q <= pid_sel;

         if (ts.ts_valid) begin
            idle <= 16'd0;
         end else if (idle != 16'(TIMEOUT)) begin
            idle <= idle + 16'd1;
         end

         if (clr_count) begin
            err_count <= {7'd0, err_event};
         end else if (err_event && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end

         if (timeout_hit) begin
            state          <= HUNT;
            signal_present <= 1'b0;
            hdr_ok         <= 1'b0;
            cc_ok          <= 1'b0;
            dup            <= 1'b0;
         end else if (ts.ts_valid) begin
            byte_idx <= last_idx ? '0 : byte_idx + IDX_W'(1);
            case (state)
               HUNT: begin
                  if (is_sync) begin
                     state    <= PRESYNC;
                     byte_idx <= IDX_W'(1);
                     good     <= 8'd1;
                  end
               end
               PRESYNC: begin
                  if (at_zero) begin
                     if (!is_sync) begin
                        state <= HUNT;
                        cc_ok <= 1'b0;
                        dup   <= 1'b0;
                     end else if (good == 8'(LOCK_COUNT - 1)) begin
                        state          <= LOCKED;
                        bad            <= 8'd0;
                        hdr_ok         <= 1'b1;
                        signal_present <= 1'b1;
                     end else begin
                        good <= good + 8'd1;
                     end
                  end
               end
               LOCKED: begin
                  if (at_zero) begin
                     if (is_sync) begin
                        bad       <= 8'd0;
                        hdr_ok    <= 1'b1;
                        pkt_start <= 1'b1;
                     end else begin
                        // A packet with a missing sync byte is not trusted for header parsing.
                        hdr_ok <= 1'b0;
                        if (loss_hit) begin
                           state          <= HUNT;
                           signal_present <= 1'b0;
                           cc_ok          <= 1'b0;
                           dup            <= 1'b0;
                        end else begin
                           bad <= bad + 8'd1;
                        end
                     end
                  end else if (hdr_ok) begin
                     if (byte_idx == IDX_W'(1)) begin
                        tei    <= ts.ts_data[7];
                        pid_hi <= ts.ts_data[4:0];
                     end else if (byte_idx == IDX_W'(2)) begin
                        pid_lo <= ts.ts_data;
                     end else if (cc_match) begin
                        last_cc <= cc;
                        cc_ok   <= 1'b1;
                        dup     <= cc_ok && ts.ts_data[4] && (cc == last_cc);
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end

         if (pid_sel != pid_sel_q) begin
            cc_ok <= 1'b0;
            dup   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ts_channel_monitor.sv
// tb/tb_ts_channel_monitor.sv - directed self-checking bench for ts_channel_monitor
module tb_ts_channel_monitor;
   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] pid_sel = 13'h100;
   logic        clr_count = 1'b0;
   logic        signal_present;
   logic [7:0]  err_count;
   logic        cc_err;
   logic        pkt_start;

   ts_channel_monitor_if bus ();

   ts_channel_monitor #(.TIMEOUT(TMO)) dut (
      .clk            (clk),
      .rst            (rst),
      .ts             (bus),
      .pid_sel        (pid_sel),
      .clr_count      (clr_count),
      .signal_present (signal_present),
      .err_count      (err_count),
      .cc_err         (cc_err),
      .pkt_start      (pkt_start)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int pulses = 0;
   int starts = 0;
   int pulse_idx = -1;
   int cur_idx = 0;
   int exp_err = 0;
   logic [3:0] lcc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic bump();
      if (exp_err < 255) exp_err++;
   endtask

   task automatic clear_counts();
      pulses = 0;
      starts = 0;
      pulse_idx = -1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      bus.ts_data  = d;
      bus.ts_valid = 1'b1;
      @(posedge clk);
      #1;
      if (cc_err) begin
         pulses++;
         pulse_idx = cur_idx;
      end
      if (pkt_start) starts++;
   endtask

   task automatic send_rest(input logic tei, input logic [12:0] pid, input logic [1:0] afc,
                            input logic [3:0] cc, input logic clr3);
      logic [7:0] d;
      for (int i = 1; i < 188; i++) begin
         case (i)
            1:       d = {tei, 2'b00, pid[12:8]};
            2:       d = pid[7:0];
            3:       d = {2'b00, afc, cc};
            default: d = 8'hFF;
         endcase
         cur_idx   = i;
         clr_count = clr3 && (i == 3);
         send_byte(d);
         clr_count = 1'b0;
      end
   endtask

   task automatic send_pkt(input logic [7:0] sync, input logic tei, input logic [12:0] pid,
                           input logic [1:0] afc, input logic [3:0] cc);
      cur_idx = 0;
      send_byte(sync);
      send_rest(tei, pid, afc, cc, 1'b0);
   endtask

   initial begin
      bus.ts_data  = 8'h00;
      bus.ts_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_present", signal_present, 0);
      check("reset_err", err_count, 0);
      check("reset_cc_err", cc_err, 0);
      check("reset_pkt_start", pkt_start, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // acquisition: lock on third sync byte
      clear_counts();
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd0);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd1);
      check("presync_not_present", signal_present, 0);
      cur_idx = 0;
      send_byte(8'h47);
      check("lock_present", signal_present, 1);
      send_rest(0, 13'h100, 2'b01, 4'd2, 0);
      check("lock_no_pkt_start", starts, 0);
      check("lock_err", err_count, exp_err);

      // CC 3,4,6: one error at byte 3
      clear_counts();
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd3);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd4);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd6);
      bump();
      check("cc_gap_pulses", pulses, 1);
      check("cc_gap_idx", pulse_idx, 3);
      check("cc_gap_err", err_count, exp_err);
      check("pkt_start_count", starts, 3);

      // single duplicate legal, double duplicate is an error
      clear_counts();
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd7);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd7);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd8);
      check("dup_once_pulses", pulses, 0);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd9);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd9);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd9);
      bump();
      check("dup_twice_pulses", pulses, 1);
      check("dup_twice_err", err_count, exp_err);

      // TEI with bad CC counts once; null PID and other PID are ignored
      clear_counts();
      send_pkt(8'h47, 1, 13'h100, 2'b01, 4'd3);
      bump();
      check("tei_pulses", pulses, 1);
      check("tei_idx", pulse_idx, 1);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd10);
      send_pkt(8'h47, 0, 13'h1FFF, 2'b01, 4'd5);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd11);
      send_pkt(8'h47, 0, 13'h200, 2'b01, 4'd0);
      check("tei_excl_null_pulses", pulses, 1);
      check("tei_err", err_count, exp_err);

      // two bad syncs then a good one keep lock; bad count restarts
      clear_counts();
      send_pkt(8'h00, 0, 13'h100, 2'b01, 4'd0);
      send_pkt(8'h00, 0, 13'h100, 2'b01, 4'd0);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd12);
      send_pkt(8'h00, 0, 13'h100, 2'b01, 4'd0);
      send_pkt(8'h00, 0, 13'h100, 2'b01, 4'd0);
      check("bad2_present", signal_present, 1);
      check("bad2_pulses", pulses, 0);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd13);
      send_pkt(8'h00, 0, 13'h100, 2'b01, 4'd0);
      send_pkt(8'h00, 0, 13'h100, 2'b01, 4'd0);
      check("bad_pre_loss_present", signal_present, 1);
      cur_idx = 0;
      send_byte(8'h00);
      bump();
      check("loss_present", signal_present, 0);
      check("loss_cc_err", cc_err, 1);
      check("loss_err", err_count, exp_err);
      send_rest(0, 13'h100, 2'b01, 4'd0, 0);

      // relock: first CC after lock only loads
      clear_counts();
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd0);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd0);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd7);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd8);
      check("relock_present", signal_present, 1);
      check("relock_pulses", pulses, 0);

      // idle timeout while locked
      bus.ts_valid = 1'b0;
      repeat (TMO - 1) @(posedge clk);
      #1;
      check("pre_timeout_present", signal_present, 1);
      @(posedge clk);
      #1;
      bump();
      check("timeout_present", signal_present, 0);
      check("timeout_cc_err", cc_err, 1);
      check("timeout_err", err_count, exp_err);

      // resume: relock, first CC not checked
      clear_counts();
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd0);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd0);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd3);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd4);
      check("resume_present", signal_present, 1);
      check("resume_pulses", pulses, 0);
      lcc = 4'd4;

      // 300 CC errors saturate the counter
      clear_counts();
      for (int i = 0; i < 300; i++) begin
         lcc = lcc + 4'd2;
         send_pkt(8'h47, 0, 13'h100, 2'b01, lcc);
         bump();
      end
      check("sat_pulses", pulses, 300);
      check("sat_err", err_count, 255);

      // clr alone, then clr coincident with an error
      clr_count = 1'b1;
      cur_idx = 0;
      send_byte(8'h47);
      clr_count = 1'b0;
      exp_err = 0;
      check("clr_err", err_count, exp_err);
      clear_counts();
      lcc = lcc + 4'd5;
      send_rest(0, 13'h100, 2'b01, lcc, 1'b1);
      exp_err = 1;
      check("clr_event_err", err_count, exp_err);
      check("clr_event_pulses", pulses, 1);
      check("clr_keeps_lock", signal_present, 1);

      // asynchronous reset mid-packet
      cur_idx = 0;
      send_byte(8'h47);
      send_byte(8'h01);
      rst = 1'b1;
      #1;
      check("midrst_present", signal_present, 0);
      check("midrst_err", err_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_counts();
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd0);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd1);
      send_pkt(8'h47, 0, 13'h100, 2'b01, 4'd2);
      check("post_rst_present", signal_present, 1);
      check("post_rst_pulses", pulses, 0);

      bus.ts_valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
